// File: rtl/speccfa_pkg.sv
// Shared definitions for the block fetch path: widths, header layout, FSM encoding.
package speccfa_pkg;

    localparam int unsigned ADDR_W          = 16;          // block memory word address
    localparam int unsigned AADDR_W         = ADDR_W + 1;  // carry-extended address arithmetic
    localparam int unsigned DATA_W          = 16;
    localparam int unsigned LEN_W           = 8;
    localparam int unsigned ID_W            = 8;
    localparam int unsigned ID_MSB          = 15;
    localparam int unsigned LEN_MSB         = 7;
    localparam int unsigned BLK_HDR_WORDS   = 1;
    localparam int unsigned BLK_ENTRY_WORDS = 2;
    localparam int unsigned MAX_LEN_DEF     = 255;

    // Header word: {id[ID_MSB:8], len[LEN_MSB:0]}
    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [LEN_W-1:0] len;
    } blk_hdr_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_SRC   = 3'd2,
        ST_DST   = 3'd3,
        ST_CAP   = 3'd4,
        ST_READY = 3'd5,
        ST_DONE  = 3'd6,
        ST_ERR   = 3'd7
    } state_t;

    // States during which a read sequence is in flight
    function automatic logic is_busy(input state_t s);
        return (s inside {ST_HDR, ST_SRC, ST_DST, ST_CAP});
    endfunction

endpackage

// File: rtl/block_entry_reader_if.sv
// Block memory read port: 1-cycle latency, rdata valid the cycle after mem_ren.
//   master (reader): drives mem_ren, mem_addr; receives mem_rdata
//   slave  (memory): receives mem_ren, mem_addr; drives mem_rdata
interface block_entry_reader_if;
    import speccfa_pkg::*;

    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_ren, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_ren, input  mem_addr, output mem_rdata);

endinterface

// File: rtl/blockmem_addr_gen.sv
// Combinational 17-bit entry address and bounds computation for one block.
//   i_base      block base word index
//   i_idx       current entry index
//   i_len       entry count of the block
//   i_mem_size  number of valid words in block memory
//   o_src_addr  base + 1 + 2*idx (17-bit)
//   o_dst_addr  base + 2 + 2*idx (17-bit)
//   o_base_oob  header word lies outside memory
//   o_len_oob   last dest word (base + 2*len) lies outside memory
module blockmem_addr_gen
    import speccfa_pkg::*;
(
    input  logic [ADDR_W-1:0]  i_base,
    input  logic [LEN_W-1:0]   i_idx,
    input  logic [LEN_W-1:0]   i_len,
    input  logic [ADDR_W-1:0]  i_mem_size,
    output logic [AADDR_W-1:0] o_src_addr,
    output logic [AADDR_W-1:0] o_dst_addr,
    output logic               o_base_oob,
    output logic               o_len_oob
);

    logic [AADDR_W-1:0] w_base;
    logic [AADDR_W-1:0] w_size;
    logic [AADDR_W-1:0] w_idx_off;
    logic [AADDR_W-1:0] w_len_off;

    // Carry into bit 16 is kept so a block wrapping past 0xFFFF reads as out of bounds
    always_comb begin
        w_base     = AADDR_W'(i_base);
        w_size     = AADDR_W'(i_mem_size);
        w_idx_off  = AADDR_W'(i_idx) * AADDR_W'(BLK_ENTRY_WORDS);
        w_len_off  = AADDR_W'(i_len) * AADDR_W'(BLK_ENTRY_WORDS);
        o_src_addr = w_base + AADDR_W'(BLK_HDR_WORDS) + w_idx_off;
        o_dst_addr = o_src_addr + AADDR_W'(1);
        o_base_oob = (w_base >= w_size);
        o_len_oob  = ((w_base + w_len_off) >= w_size);
    end

endmodule

// File: rtl/block_entry_reader.sv
// Walks one block's header and src/dest entry pairs over the block memory read port
// and presents the current expected entry to the fetch/detect logic.
//   clk, rst_n        clock, async active-low reset
//   block_base        base word of the block to read (latched on base_load)
//   base_load         pulse: start a new block (aborts any current sequence)
//   entry_adv         pulse: current entry consumed (honoured only in READY)
//   BLOCKMEM_size     number of valid words in block memory
//   mem               block memory read port (master side)
//   block_entry_src   expected source address of current entry
//   block_entry_dest  expected destination address of current entry
//   block_len/id      captured header fields
//   entry_idx         current entry index
//   entry_valid       src/dest/idx valid
//   block_done        every entry consumed or len==0
//   block_err         one-cycle pulse: block outside memory or len too large
//   busy              read sequence in flight
module block_entry_reader
    import speccfa_pkg::*;
#(
    parameter int unsigned MAX_LEN = MAX_LEN_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_W-1:0]    block_base,
    input  logic                 base_load,
    input  logic                 entry_adv,
    input  logic [ADDR_W-1:0]    BLOCKMEM_size,
    block_entry_reader_if.master mem,
    output logic [DATA_W-1:0]    block_entry_src,
    output logic [DATA_W-1:0]    block_entry_dest,
    output logic [LEN_W-1:0]     block_len,
    output logic [LEN_W-1:0]     block_id,
    output logic [LEN_W-1:0]     entry_idx,
    output logic                 entry_valid,
    output logic                 block_done,
    output logic                 block_err,
    output logic                 busy
);

    localparam int unsigned LEN_XW = LEN_W + 1;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base;
    logic                r_first;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_id;
    logic [LEN_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_src;
    logic [DATA_W-1:0]   r_dest;
    logic                r_entry_valid;
    logic                r_block_done;
    logic                r_block_err;
    logic                r_busy;

    blk_hdr_t            w_hdr;
    logic [LEN_W-1:0]    w_cur_len;
    logic                w_len_bad;
    logic                w_last_entry;
    logic [AADDR_W-1:0]  w_src_addr;
    logic [AADDR_W-1:0]  w_dst_addr;
    logic                w_base_oob;
    logic                w_len_oob;
    logic                w_rd_req;
    logic [AADDR_W-1:0]  w_rd_addr;
    logic                w_rd_inb;

    // In the first SRC cycle the header is still on rdata; later SRC visits use the captured len
    always_comb begin
        w_hdr        = blk_hdr_t'(mem.mem_rdata);
        w_cur_len    = r_first ? w_hdr.len : r_len;
        w_len_bad    = (LEN_XW'(w_cur_len) > LEN_XW'(MAX_LEN)) || w_len_oob;
        w_last_entry = ((LEN_XW'(r_idx) + LEN_XW'(1)) == LEN_XW'(r_len));
    end

    blockmem_addr_gen u_addr_gen (
        .i_base     (r_base),
        .i_idx      (r_idx),
        .i_len      (w_cur_len),
        .i_mem_size (BLOCKMEM_size),
        .o_src_addr (w_src_addr),
        .o_dst_addr (w_dst_addr),
        .o_base_oob (w_base_oob),
        .o_len_oob  (w_len_oob)
    );

    // Next state and read request; base_load overrides every other transition
    always_comb begin
        w_next    = r_state;
        w_rd_req  = 1'b0;
        w_rd_addr = '0;
        case (r_state)
            ST_HDR: begin
                if (w_base_oob) begin
                    w_next = ST_ERR;
                end else begin
                    w_rd_req  = 1'b1;
                    w_rd_addr = AADDR_W'(r_base);
                    w_next    = ST_SRC;
                end
            end
            ST_SRC: begin
                if (w_cur_len == '0) begin
                    w_next = ST_DONE;
                end else if (w_len_bad) begin
                    w_next = ST_ERR;
                end else begin
                    w_rd_req  = 1'b1;
                    w_rd_addr = w_src_addr;
                    w_next    = ST_DST;
                end
            end
            ST_DST: begin
                w_rd_req  = 1'b1;
                w_rd_addr = w_dst_addr;
                w_next    = ST_CAP;
            end
            ST_CAP:   w_next = ST_READY;
            ST_READY: begin
                if (entry_adv) begin
                    w_next = w_last_entry ? ST_DONE : ST_SRC;
                end
            end
            ST_ERR:   w_next = ST_IDLE;
            default:  w_next = r_state;
        endcase
        if (base_load) begin
            w_next = ST_HDR;
        end
    end

    // Last-line guard: the port is never driven with an out-of-range address
    always_comb begin
        w_rd_inb = (w_rd_addr < AADDR_W'(BLOCKMEM_size));
    end

    assign mem.mem_ren  = w_rd_req && w_rd_inb;
    assign mem.mem_addr = (w_rd_req && w_rd_inb) ? w_rd_addr[ADDR_W-1:0] : '0;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Base latch, header/entry capture, entry index and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_base        <= '0;
            r_first       <= 1'b0;
            r_len         <= '0;
            r_id          <= '0;
            r_idx         <= '0;
            r_src         <= '0;
            r_dest        <= '0;
            r_entry_valid <= 1'b0;
            r_block_done  <= 1'b0;
            r_block_err   <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            if (base_load) begin
                r_base  <= block_base;
                r_first <= 1'b1;
                r_idx   <= '0;
                r_src   <= '0;
                r_dest  <= '0;
            end else begin
                if (r_state == ST_SRC && r_first) begin
                    r_len   <= w_hdr.len;
                    r_id    <= w_hdr.id;
                    r_first <= 1'b0;
                end
                if (r_state == ST_DST) begin
                    r_src <= mem.mem_rdata;
                end
                if (r_state == ST_CAP) begin
                    r_dest <= mem.mem_rdata;
                end
                if (r_state == ST_READY && entry_adv && !w_last_entry) begin
                    r_idx <= r_idx + LEN_W'(1);
                end
            end
            // An erroring block leaves nothing behind for the consumer
            if (w_next == ST_ERR) begin
                r_len  <= '0;
                r_id   <= '0;
                r_idx  <= '0;
                r_src  <= '0;
                r_dest <= '0;
            end
            r_entry_valid <= (w_next == ST_READY);
            r_block_done  <= (w_next == ST_DONE);
            r_block_err   <= (w_next == ST_ERR);
            r_busy        <= is_busy(w_next);
        end
    end

    assign block_entry_src  = r_src;
    assign block_entry_dest = r_dest;
    assign block_len        = r_len;
    assign block_id         = r_id;
    assign entry_idx        = r_idx;
    assign entry_valid      = r_entry_valid;
    assign block_done       = r_block_done;
    assign block_err        = r_block_err;
    assign busy             = r_busy;

endmodule

// File: tb/tb_block_entry_reader.sv
// Directed self-checking bench for block_entry_reader with a 64-word, 1-cycle-latency memory.
module tb_block_entry_reader;

    logic        clk;
    logic        rst_n;
    logic [15:0] block_base;
    logic        base_load;
    logic        entry_adv;
    logic [15:0] mem_size;
    logic [15:0] block_entry_src;
    logic [15:0] block_entry_dest;
    logic [7:0]  block_len;
    logic [7:0]  block_id;
    logic [7:0]  entry_idx;
    logic        entry_valid;
    logic        block_done;
    logic        block_err;
    logic        busy;

    logic [15:0] mem [64];
    int          n_checks;
    int          n_errors;
    int          rd_cnt;
    logic        valid_seen;
    logic        oob_seen;

    block_entry_reader_if bus ();

    block_entry_reader dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .block_base       (block_base),
        .base_load        (base_load),
        .entry_adv        (entry_adv),
        .BLOCKMEM_size    (mem_size),
        .mem              (bus),
        .block_entry_src  (block_entry_src),
        .block_entry_dest (block_entry_dest),
        .block_len        (block_len),
        .block_id         (block_id),
        .entry_idx        (entry_idx),
        .entry_valid      (entry_valid),
        .block_done       (block_done),
        .block_err        (block_err),
        .busy             (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: data appears the cycle after the read
    always @(posedge clk) begin
        if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr[5:0]];
    end

    always @(negedge clk) begin
        if (bus.mem_ren) rd_cnt = rd_cnt + 1;
        if (bus.mem_ren && bus.mem_addr >= 16'd64) oob_seen = 1'b1;
        if (entry_valid) valid_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] b);
        block_base = b;
        base_load  = 1'b1;
        tick();
        base_load  = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rd_cnt     = 0;
        valid_seen = 1'b0;
        oob_seen   = 1'b0;
        rst_n      = 1'b0;
        base_load  = 1'b0;
        entry_adv  = 1'b0;
        block_base = 16'd0;
        mem_size   = 16'd64;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h0302; mem[1]  = 16'he100; mem[2]  = 16'he200;
        mem[3]  = 16'he110; mem[4]  = 16'he210;
        mem[5]  = 16'h0700;
        mem[10] = 16'h0B01; mem[11] = 16'ha011; mem[12] = 16'ha012;
        mem[60] = 16'h0A03;

        // Reset state
        ticks(2);
        check("rst_flags", 64'({entry_valid, block_done, block_err, busy, bus.mem_ren}), 64'd0);
        check("rst_data", 64'({block_entry_src, block_entry_dest, block_len, block_id, entry_idx}), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1: two-entry block at base 0
        rd_cnt = 0;
        load(16'd0);
        check("t1_busy_hdr", 64'(busy), 64'd1);
        ticks(3);
        check("t1_not_yet", 64'(entry_valid), 64'd0);
        tick();
        check("t1_valid0", 64'(entry_valid), 64'd1);
        check("t1_entry0", 64'({block_entry_src, block_entry_dest, block_id, block_len, entry_idx}),
              64'({16'he100, 16'he200, 8'h03, 8'h02, 8'h00}));
        entry_adv = 1'b1; tick(); entry_adv = 1'b0;
        check("t1_adv_drop", 64'({entry_valid, busy}), 64'b01);
        ticks(2);
        check("t1_adv_wait", 64'(entry_valid), 64'd0);
        tick();
        check("t1_entry1", 64'({entry_valid, block_entry_src, block_entry_dest, entry_idx}),
              64'({1'b1, 16'he110, 16'he210, 8'h01}));
        entry_adv = 1'b1; tick(); entry_adv = 1'b0;
        check("t1_done", 64'({block_done, entry_valid, busy, block_id, block_len}),
              64'({1'b1, 1'b0, 1'b0, 8'h03, 8'h02}));
        check("t1_reads", 64'(rd_cnt), 64'd5);

        // 2: len 0 block -> done two edges after load, header read only
        rd_cnt = 0; valid_seen = 1'b0;
        load(16'd5);
        check("t2_done_drop", 64'(block_done), 64'd0);
        tick();
        check("t2_src_ren", 64'({bus.mem_ren, block_done}), 64'd0);
        tick();
        check("t2_done", 64'({block_done, block_len, block_id}), 64'({1'b1, 8'h00, 8'h07}));
        ticks(3);
        check("t2_novalid", 64'({valid_seen, block_done}), 64'b01);
        check("t2_reads", 64'(rd_cnt), 64'd1);

        // 3: block running past memory end -> error pulse, outputs cleared
        rd_cnt = 0;
        load(16'd60);
        tick();
        check("t3_src", 64'({bus.mem_ren, block_err}), 64'd0);
        tick();
        check("t3_err", 64'({block_err, entry_valid, block_done, busy}), 64'b1000);
        check("t3_err_data", 64'({block_entry_src, block_entry_dest, block_len, block_id, entry_idx}), 64'd0);
        tick();
        check("t3_idle", 64'({block_err, busy}), 64'd0);
        check("t3_reads", 64'(rd_cnt), 64'd1);
        entry_adv = 1'b1; tick(); entry_adv = 1'b0;
        check("t3_adv_idle", 64'({entry_valid, block_done, block_err, busy}), 64'd0);
        // base equal to memory size -> error one edge after load, no read at all
        rd_cnt = 0;
        load(16'd64);
        check("t3b_hdr_noren", 64'({bus.mem_ren, block_err}), 64'd0);
        tick();
        check("t3b_err", 64'(block_err), 64'd1);
        tick();
        check("t3b_pulse", 64'({block_err, rd_cnt[7:0]}), 64'd0);

        // 4: reload during DST discards the first block
        load(16'd0);
        ticks(2);
        load(16'd10);
        check("t4_abort", 64'({entry_valid, block_done, busy}), 64'b001);
        ticks(3);
        check("t4_wait", 64'(entry_valid), 64'd0);
        tick();
        check("t4_entry", 64'({entry_valid, block_entry_src, block_entry_dest, block_id, block_len, entry_idx}),
              64'({1'b1, 16'ha011, 16'ha012, 8'h0b, 8'h01, 8'h00}));

        // 5: base_load beats a simultaneous entry_adv (would otherwise finish block 10)
        entry_adv = 1'b1;
        load(16'd0);
        entry_adv = 1'b0;
        check("t5_restart", 64'({entry_valid, block_done, busy, entry_idx}), 64'({3'b001, 8'h00}));
        ticks(4);
        check("t5_entry", 64'({entry_valid, block_entry_src, block_entry_dest, block_len, entry_idx}),
              64'({1'b1, 16'he100, 16'he200, 8'h02, 8'h00}));
        load(16'd10);
        ticks(4);
        entry_adv = 1'b1; tick(); entry_adv = 1'b0;
        check("t5_done", 64'(block_done), 64'd1);
        entry_adv = 1'b1; tick(); entry_adv = 1'b0;
        check("t5_adv_done", 64'({block_done, entry_valid, busy, block_len, block_id}),
              64'({3'b100, 8'h01, 8'h0b}));

        // 6: async reset mid-SRC clears everything immediately, then normal operation
        load(16'd0);
        tick();
        rst_n = 1'b0;
        #1;
        check("t6_rst_flags", 64'({entry_valid, block_done, block_err, busy, bus.mem_ren}), 64'd0);
        check("t6_rst_data", 64'({block_entry_src, block_entry_dest, block_len, block_id, entry_idx}), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        load(16'd0);
        ticks(4);
        check("t6_entry", 64'({entry_valid, block_entry_src, block_entry_dest, block_len}),
              64'({1'b1, 16'he100, 16'he200, 8'h02}));
        check("oob_reads", 64'(oob_seen), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
